// File: rtl/nios2_ocimem_arbiter.sv
// nios2_ocimem_arbiter
//   Arbitrates the debug module's single-port OCI RAM between the JTAG debug
//   path and the CPU debug-monitor slave port. It runs in the system clock
//   domain.
//
//   JTAG side
//     - There is no backpressure. One command is held in a 1-deep pending
//       register.
//     - Accesses use an auto-incrementing word pointer.
//     - Results go back through mon_dreg and mon_ready.
//
//   CPU side
//     - Avalon-style read/write handshake with cpu_waitrequest.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   jtag_load_addr, jtag_access single-cycle JTAG action pulses
//   jdo[37:0]                   JTAG payload:
//                                 [ADDR_W+1:2] = address
//                                 [35]         = write
//                                 [34:3]       = data
//   cpu_*                       CPU slave port
//   ram_*                       RAM port; ram_rdata has 1-cycle latency
//   mon_dreg, mon_ready         JTAG read data and idle/complete status
//   jtag_overrun                sticky flag: a JTAG command was dropped
//
// Configuration
//   NIOS2_OCIMEM_ARB_FAIR_EN
//     When defined, arbitration alternates between JTAG and CPU when both
//     contend. Otherwise JTAG has strict priority.
//
// DATA_W must be 32, because the JTAG payload carries exactly 32 data bits.
module nios2_ocimem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              jtag_load_addr,
   input  logic              jtag_access,
   input  logic [37:0]       jdo,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_writedata,
   output logic [DATA_W-1:0] cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] mon_dreg,
   output logic              mon_ready,
   output logic              jtag_overrun
);

   typedef enum logic [2:0] {S_IDLE, S_JGNT, S_JRD, S_CGNT, S_CRD} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   jptr_q;
   logic                pending_q;
   logic                op_wr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   mon_dreg_q;
   logic                mon_ready_q;
   logic                overrun_q;
`ifdef NIOS2_OCIMEM_ARB_FAIR_EN
   logic                last_jtag_q;
`endif

   logic jtag_accept;
   logic jtag_req;
   logic cpu_req;
   logic jtag_done;
   logic cpu_done;
   logic grant_j;
   logic grant_c;
   logic unused_jdo;

   assign unused_jdo = &{1'b0, jdo[37:36], jdo[1:0]};

   // A new pulse is accepted only when no command is already held.
   // The pulse is also visible to IDLE in the same cycle, so the grant is
   // not delayed by the pending register.
   assign jtag_accept = jtag_access & ~pending_q;
   assign jtag_req    = pending_q | jtag_access;
   assign cpu_req     = cpu_read | cpu_write;

   always_comb begin
      state_d         = state_q;
      ram_addr        = '0;
      ram_wren        = 1'b0;
      ram_wdata       = '0;
      cpu_readdata    = '0;
      jtag_done       = 1'b0;
      cpu_done        = 1'b0;
      grant_j         = 1'b0;
      grant_c         = 1'b0;
      cpu_waitrequest = 1'b0;

      case (state_q)
         S_IDLE: begin
`ifdef NIOS2_OCIMEM_ARB_FAIR_EN
            // JTAG yields to a waiting CPU once it has had the last grant.
            if (jtag_req && !(cpu_req && last_jtag_q)) grant_j = 1'b1;
            else if (cpu_req)                          grant_c = 1'b1;
`else
            if (jtag_req)     grant_j = 1'b1;
            else if (cpu_req) grant_c = 1'b1;
`endif
            if (grant_j)      state_d = S_JGNT;
            else if (grant_c) state_d = S_CGNT;
         end
         S_JGNT: begin
            ram_addr = jptr_q;
            if (op_wr_q) begin
               ram_wren  = 1'b1;
               ram_wdata = wdata_q;
               jtag_done = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d   = S_JRD;
            end
         end
         S_JRD: begin
            jtag_done = 1'b1;
            state_d   = S_IDLE;
         end
         S_CGNT: begin
            ram_addr = cpu_address;
            if (cpu_write) begin
               ram_wren  = 1'b1;
               ram_wdata = cpu_writedata;
               cpu_done  = 1'b1;
               state_d   = S_IDLE;
            end else if (cpu_read) begin
               state_d   = S_CRD;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_CRD: begin
            cpu_readdata = ram_rdata;
            cpu_done     = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      cpu_waitrequest = cpu_req & ~cpu_done;

      // Reset forces the RAM port and the CPU handshake quiet at once.
      // An in-flight access must not complete while reset is asserted.
      if (reset) begin
         state_d         = S_IDLE;
         ram_addr        = '0;
         ram_wren        = 1'b0;
         ram_wdata       = '0;
         cpu_readdata    = '0;
         cpu_waitrequest = 1'b0;
         jtag_done       = 1'b0;
         cpu_done        = 1'b0;
         grant_j         = 1'b0;
         grant_c         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         jptr_q      <= '0;
         pending_q   <= 1'b0;
         op_wr_q     <= 1'b0;
         wdata_q     <= '0;
         mon_dreg_q  <= '0;
         mon_ready_q <= 1'b1;
         overrun_q   <= 1'b0;
`ifdef NIOS2_OCIMEM_ARB_FAIR_EN
         last_jtag_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;

         // Completion only happens while pending, and a load is ignored
         // while pending, so these two updates never collide.
         if (jtag_load_addr && !pending_q)
            jptr_q <= jdo[ADDR_W+1:2];
         else if (jtag_done)
            jptr_q <= jptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

         if (jtag_accept) begin
            pending_q   <= 1'b1;
            op_wr_q     <= jdo[35];
            wdata_q     <= jdo[34:3];
            mon_ready_q <= 1'b0;
         end else if (jtag_done) begin
            pending_q   <= 1'b0;
            mon_ready_q <= 1'b1;
         end

         if (state_q == S_JRD)
            mon_dreg_q <= ram_rdata;

         if ((jtag_access || jtag_load_addr) && pending_q)
            overrun_q <= 1'b1;

`ifdef NIOS2_OCIMEM_ARB_FAIR_EN
         if (grant_j)      last_jtag_q <= 1'b1;
         else if (grant_c) last_jtag_q <= 1'b0;
`endif
      end
   end

   assign mon_dreg     = mon_dreg_q;
   assign mon_ready    = mon_ready_q;
   assign jtag_overrun = overrun_q;

endmodule

// File: doc/nios2_ocimem_arbiter.md
Name: nios2_ocimem_arbiter

Overview:
- Sysclk-domain controller for the debug module's single-port on-chip debug RAM (OCI memory).
- Shares the RAM between two requesters:
  - the JTAG debug path, driven by take_action pulses and the 38-bit jdo payload from the debug module;
  - the CPU debug-monitor slave port.
- Sequences JTAG accesses with an auto-incrementing address pointer and returns read data and ready status to the JTAG shift register (MonDReg / monitor_ready).

Parameters:
- ADDR_W, 8, word-address width of the debug RAM (depth 2^ADDR_W words).
- DATA_W, 32, RAM data width; must equal 32, because the JTAG payload carries 32 data bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jtag_load_addr  in  1  single-cycle pulse (take_action_ocimem_a); loads the JTAG address pointer.
- jtag_access  in  1  single-cycle pulse (take_action_ocimem_b); requests one JTAG RAM access.
- jdo  in  38  JTAG payload, with fields:
  - [ADDR_W+1:2] = word address, used on load;
  - [35] = 1 write / 0 read;
  - [34:3] = write data.
- cpu_address  in  ADDR_W  CPU word address.
- cpu_read  in  1  CPU read request, held until accepted.
- cpu_write  in  1  CPU write request, held until accepted.
- cpu_writedata  in  32  CPU write data.
- cpu_readdata  out  32  CPU read data, valid when cpu_read=1 and cpu_waitrequest=0.
- cpu_waitrequest  out  1  stall for the CPU requester.
- ram_addr  out  ADDR_W  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; 1-cycle registered latency.
- mon_dreg  out  32  last JTAG read data (MonDReg).
- mon_ready  out  1  JTAG access idle/complete (monitor_ready).
- jtag_overrun  out  1  sticky error flag; a JTAG command was dropped.

Behaviour:

Reset:
- All state is cleared on a synchronous reset: FSM returns to IDLE, JTAG pending flag cleared, address pointer = 0.
- Output values during and after reset: mon_dreg = 0, mon_ready = 1, jtag_overrun = 0, ram_wren = 0, ram_addr = 0, cpu_waitrequest = 0.
- A reset asserted mid-operation aborts any in-flight access. The CPU must reissue; the JTAG command is lost.

JTAG front end (no backpressure, so it uses a 1-deep pending register):
- jtag_load_addr: jptr <= jdo[ADDR_W+1:2].
- jtag_access: latches the op ([35]) and data ([34:3]), sets pending, and clears mon_ready on the next cycle.
- If load_addr and access arrive in the same cycle, the access uses the newly loaded address.
- jtag_access while pending is already set:
  - the command is dropped;
  - jtag_overrun is set and stays 1 until reset.
- jtag_load_addr while pending: the pointer is not changed and jtag_overrun is set.

FSM states: IDLE, JGNT, JRD, CGNT, CRD.

IDLE (arbitration, when both requesters want the RAM):
- JTAG pending wins (strict priority) → JGNT.
- Otherwise, if cpu_read or cpu_write is asserted → CGNT.

JGNT:
- ram_addr = jptr.
- Write op: ram_wren = 1 and ram_wdata = latched data; then clear pending, set mon_ready, jptr += 1 (modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0); → IDLE.
- Read op: → JRD.

JRD:
- mon_dreg <= ram_rdata; clear pending, set mon_ready, jptr += 1 (same wrap rule); → IDLE.

CGNT:
- ram_addr = cpu_address.
- Write: ram_wren = 1, ram_wdata = cpu_writedata, cpu_waitrequest = 0 this cycle; → IDLE.
- Read: → CRD.

CRD:
- cpu_readdata = ram_rdata, cpu_waitrequest = 0; → IDLE.

cpu_waitrequest:
- Equals (cpu_read | cpu_write) & ~(completing cycle). The completing cycle is the CGNT cycle for a write and the CRD cycle for a read.

Latencies:
- JTAG write: 2 cycles from pulse to mon_ready = 1.
- JTAG read: 3 cycles from pulse to mon_ready = 1.
- CPU uncontended: write completes in the 2nd cycle, read in the 3rd.

Simultaneous events:
- A CPU request that arrives during any JTAG state waits.
- A jtag_access that arrives during a CPU state is held as pending and is served on the next IDLE.

Optional Feature:
- Macro: NIOS2_OCIMEM_ARB_FAIR_EN.
- Defined: alternating fairness. A flag last_jtag is set on each JGNT and cleared on each CGNT. In IDLE, if both requesters want the RAM and last_jtag = 1, the CPU wins.
- Undefined: strict JTAG priority, and last_jtag is not implemented.

Test Plan:
- Reset, then pulse load_addr with address 0x10, then jtag_access write with jdo[35]=1, data 0xDEADBEEF → one cycle with ram_wren = 1 at addr 0x10, mon_ready low for exactly 1 cycle, jptr = 0x11.
- jtag_access read with RAM[0x11] = 0x12345678 → mon_dreg = 0x12345678 three cycles after the pulse, jptr = 0x12.
- Load address 0xFF, then two JTAG writes → RAM writes at 0xFF, then 0x00 (wrap).
- CPU read of addr 0x05 issued the same cycle as a JTAG access:
  - macro undefined → JTAG served first; CPU readdata valid 3 cycles later than uncontended, with waitrequest high until then;
  - macro defined, after a prior JTAG grant → CPU served first.
- Second jtag_access pulse while the first is still pending → second command dropped, jtag_overrun = 1 and stays 1 until reset.
- Reset asserted in CRD → next cycle: FSM in IDLE, mon_ready = 1, ram_wren = 0, jtag_overrun = 0.
